// File: rtl/conv_stream_feeder.sv
// Per (kernel, channel): 2 kernel words, then 61 rows x 32 column-pair fmap words; start->first out_valid is 3 edges.
// One word per cycle; in_hold freezes counters, pipeline and outputs, and gates both SRAM read enables.
module conv_stream_feeder #(
  parameter int DATA_W   = 8,
  parameter int FMAP_DIM = 64,
  parameter int KNL_DIM  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_start,
  input  logic                     in_hold,
  input  logic [2:0]               in_cfg_ci,
  input  logic [2:0]               in_cfg_co,
  output logic [10:0]              out_knl_addr,
  output logic                     out_knl_re,
  input  logic [8*DATA_W-1:0]      in_knl_rdata,
  output logic [15:0]              out_fm_addr0,
  output logic [15:0]              out_fm_addr1,
  output logic [15:0]              out_fm_addr2,
  output logic [15:0]              out_fm_addr3,
  output logic                     out_fm_re,
  input  logic [2*DATA_W-1:0]      in_fm_rdata0,
  input  logic [2*DATA_W-1:0]      in_fm_rdata1,
  input  logic [2*DATA_W-1:0]      in_fm_rdata2,
  input  logic [2*DATA_W-1:0]      in_fm_rdata3,
  output logic signed [DATA_W-1:0] out_data0,
  output logic signed [DATA_W-1:0] out_data1,
  output logic signed [DATA_W-1:0] out_data2,
  output logic signed [DATA_W-1:0] out_data3,
  output logic signed [DATA_W-1:0] out_data4,
  output logic signed [DATA_W-1:0] out_data5,
  output logic signed [DATA_W-1:0] out_data6,
  output logic signed [DATA_W-1:0] out_data7,
  output logic                     out_valid,
  output logic                     out_knl,
  output logic                     out_busy,
  output logic                     out_done
);
  localparam int OUT_DIM = FMAP_DIM - KNL_DIM + 1;
  localparam int PAIRS   = FMAP_DIM / 2;
  localparam int RW      = $clog2(OUT_DIM);
  localparam int PW      = $clog2(PAIRS);
  localparam logic [RW-1:0] R_LAST = RW'(OUT_DIM - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PAIRS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [4:0]          k_q, k_d, c_q, c_d;
  logic [4:0]          nci_m1_q, nci_m1_d, nco_m1_q, nco_m1_d;
  logic [RW-1:0]       r_q, r_d;
  logic [PW-1:0]       p_q, p_d;
  logic                w_q, w_d, knl_ph_q, knl_ph_d;
  logic [10:0]         knl_addr_q, knl_addr_d, knl_addr_nx;
  logic [15:0]         fm_addr_q [4];
  logic [15:0]         fm_addr_d [4];
  logic [15:0]         fm_addr_nx [4];
  logic                knl_re_q, knl_re_d, fm_re_q, fm_re_d;
  logic                vld_b_q, vld_b_d, knl_b_q, knl_b_d;
  logic                vld_c_q, vld_c_d, knl_c_q, knl_c_d;
  logic [DATA_W-1:0]   data_q [8];
  logic [DATA_W-1:0]   data_d [8];
  logic [DATA_W-1:0]   lane [8];
  logic [2*DATA_W-1:0] fm_rdata [4];
  logic                adv, last_addr, busy, done;

  function automatic logic [4:0] cfg_last(input logic [2:0] cfg);
    case (cfg)
      3'd0:    return 5'd7;
      3'd1:    return 5'd15;
      3'd2:    return 5'd23;
      default: return 5'd31;
    endcase
  endfunction

  assign fm_rdata[0] = in_fm_rdata0;
  assign fm_rdata[1] = in_fm_rdata1;
  assign fm_rdata[2] = in_fm_rdata2;
  assign fm_rdata[3] = in_fm_rdata3;

  assign adv       = (state_q == S_RUN) && !in_hold;
  assign last_addr = !knl_ph_q && (p_q == P_LAST) && (r_q == R_LAST) &&
                     (c_q == nci_m1_q) && (k_q == nco_m1_q);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_start) state_d = S_RUN;
      S_RUN:   if (adv && last_addr) state_d = S_DRAIN;
      S_DRAIN: if (!in_hold && !knl_re_q && !fm_re_q && !vld_b_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

  always_comb begin
    knl_addr_nx = 11'((int'(k_q) * (int'(nci_m1_q) + 1) + int'(c_q)) * 2 + int'(w_q));
    for (int i = 0; i < 4; i++) begin
      fm_addr_nx[i] = 16'(int'(c_q) * FMAP_DIM * PAIRS + (int'(r_q) + i) * PAIRS + int'(p_q));
    end
  end

  // Fmap words put the even column of rows r..r+3 on lanes 0..3 and the odd column on lanes 4..7.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i]     = fm_rdata[i][DATA_W-1:0];
      lane[i + 4] = fm_rdata[i][2*DATA_W-1:DATA_W];
    end
    if (knl_b_q) begin
      for (int n = 0; n < 8; n++) lane[n] = in_knl_rdata[n*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    k_d        = k_q;
    c_d        = c_q;
    r_d        = r_q;
    p_d        = p_q;
    w_d        = w_q;
    knl_ph_d   = knl_ph_q;
    nci_m1_d   = nci_m1_q;
    nco_m1_d   = nco_m1_q;
    knl_addr_d = knl_addr_q;
    fm_addr_d  = fm_addr_q;
    knl_re_d   = knl_re_q;
    fm_re_d    = fm_re_q;
    vld_b_d    = vld_b_q;
    knl_b_d    = knl_b_q;
    vld_c_d    = vld_c_q;
    knl_c_d    = knl_c_q;
    data_d     = data_q;

    if ((state_q == S_IDLE) && in_start) begin
      k_d      = '0;
      c_d      = '0;
      r_d      = '0;
      p_d      = '0;
      w_d      = 1'b0;
      knl_ph_d = 1'b1;
      nci_m1_d = cfg_last(in_cfg_ci);
      nco_m1_d = cfg_last(in_cfg_co);
    end

    if (adv) begin
      knl_addr_d = knl_addr_nx;
      fm_addr_d  = fm_addr_nx;
      knl_re_d   = knl_ph_q;
      fm_re_d    = !knl_ph_q;
      if (knl_ph_q) begin
        w_d = !w_q;
        if (w_q) knl_ph_d = 1'b0;
      end else if (p_q != P_LAST) begin
        p_d = p_q + 1'b1;
      end else begin
        p_d = '0;
        if (r_q != R_LAST) begin
          r_d = r_q + 1'b1;
        end else begin
          r_d      = '0;
          knl_ph_d = 1'b1;
          if (c_q != nci_m1_q) begin
            c_d = c_q + 5'd1;
          end else begin
            c_d = '0;
            if (k_q != nco_m1_q) k_d = k_q + 5'd1;
          end
        end
      end
    end else if (!in_hold) begin
      knl_re_d = 1'b0;
      fm_re_d  = 1'b0;
    end

    // Stages B and C advance in lockstep with stage A; the SRAM keeps rdata while re is low.
    if (!in_hold) begin
      vld_b_d = knl_re_q || fm_re_q;
      knl_b_d = knl_re_q;
      vld_c_d = vld_b_q;
      if (vld_b_q) begin
        knl_c_d = knl_b_q;
        data_d  = lane;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q        <= '0;
      c_q        <= '0;
      r_q        <= '0;
      p_q        <= '0;
      w_q        <= 1'b0;
      knl_ph_q   <= 1'b1;
      nci_m1_q   <= '0;
      nco_m1_q   <= '0;
      knl_addr_q <= '0;
      knl_re_q   <= 1'b0;
      fm_re_q    <= 1'b0;
      vld_b_q    <= 1'b0;
      knl_b_q    <= 1'b0;
      vld_c_q    <= 1'b0;
      knl_c_q    <= 1'b0;
      for (int i = 0; i < 4; i++) fm_addr_q[i] <= '0;
      for (int n = 0; n < 8; n++) data_q[n] <= '0;
    end else begin
      k_q        <= k_d;
      c_q        <= c_d;
      r_q        <= r_d;
      p_q        <= p_d;
      w_q        <= w_d;
      knl_ph_q   <= knl_ph_d;
      nci_m1_q   <= nci_m1_d;
      nco_m1_q   <= nco_m1_d;
      knl_addr_q <= knl_addr_d;
      knl_re_q   <= knl_re_d;
      fm_re_q    <= fm_re_d;
      vld_b_q    <= vld_b_d;
      knl_b_q    <= knl_b_d;
      vld_c_q    <= vld_c_d;
      knl_c_q    <= knl_c_d;
      fm_addr_q  <= fm_addr_d;
      data_q     <= data_d;
    end
  end

  assign out_knl_addr = knl_addr_q;
  assign out_fm_addr0 = fm_addr_q[0];
  assign out_fm_addr1 = fm_addr_q[1];
  assign out_fm_addr2 = fm_addr_q[2];
  assign out_fm_addr3 = fm_addr_q[3];
  assign out_knl_re   = knl_re_q && !in_hold;
  assign out_fm_re    = fm_re_q && !in_hold;
  assign out_data0    = data_q[0];
  assign out_data1    = data_q[1];
  assign out_data2    = data_q[2];
  assign out_data3    = data_q[3];
  assign out_data4    = data_q[4];
  assign out_data5    = data_q[5];
  assign out_data6    = data_q[6];
  assign out_data7    = data_q[7];
  assign out_valid    = vld_c_q && !in_hold;
  assign out_knl      = knl_c_q;
  assign out_busy     = busy;
  assign out_done     = done;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Two feeders (64x64 fmap and a shrunk 8x8 one that can run to completion quickly) against an
// SRAM model whose read data encodes the address, so every output word pins down the addresses issued.
module tb_conv_stream_feeder;
  typedef struct packed { logic knl; logic [63:0] d; } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        start [2];
  logic        hold [2];
  logic [2:0]  ci [2];
  logic [2:0]  co [2];
  logic [10:0] knl_addr [2];
  logic        knl_re [2];
  logic [63:0] knl_rdata [2];
  logic [15:0] fm_addr [2][4];
  logic        fm_re [2];
  logic [15:0] fm_rdata [2][4];
  logic [7:0]  dat [2][8];
  logic        valid [2];
  logic        knl [2];
  logic        busy [2];
  logic        done [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    conv_stream_feeder #(.DATA_W(8), .FMAP_DIM(g == 0 ? 64 : 8), .KNL_DIM(4)) dut (
      .clk(clk), .rst(rst[g]), .in_start(start[g]), .in_hold(hold[g]),
      .in_cfg_ci(ci[g]), .in_cfg_co(co[g]),
      .out_knl_addr(knl_addr[g]), .out_knl_re(knl_re[g]), .in_knl_rdata(knl_rdata[g]),
      .out_fm_addr0(fm_addr[g][0]), .out_fm_addr1(fm_addr[g][1]),
      .out_fm_addr2(fm_addr[g][2]), .out_fm_addr3(fm_addr[g][3]), .out_fm_re(fm_re[g]),
      .in_fm_rdata0(fm_rdata[g][0]), .in_fm_rdata1(fm_rdata[g][1]),
      .in_fm_rdata2(fm_rdata[g][2]), .in_fm_rdata3(fm_rdata[g][3]),
      .out_data0(dat[g][0]), .out_data1(dat[g][1]), .out_data2(dat[g][2]), .out_data3(dat[g][3]),
      .out_data4(dat[g][4]), .out_data5(dat[g][5]), .out_data6(dat[g][6]), .out_data7(dat[g][7]),
      .out_valid(valid[g]), .out_knl(knl[g]), .out_busy(busy[g]), .out_done(done[g])
    );
  end

  function automatic logic [63:0] knl_mem(input logic [10:0] a);
    return {a[7:0] ^ 8'h5a, {5'd0, a[10:8]} ^ 8'h33, a[7:0] + 8'd17, a[7:0] ^ 8'hc3,
            {5'd0, a[10:8]} ^ 8'hf0, ~a[7:0], {5'd0, a[10:8]}, a[7:0]};
  endfunction

  // SRAMs: 1-cycle latency, read data retained while re is low; fmap word = its own address.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (knl_re[g]) knl_rdata[g] <= knl_mem(knl_addr[g]);
      if (fm_re[g]) for (int i = 0; i < 4; i++) fm_rdata[g][i] <= fm_addr[g][i];
    end
  end

  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  longint last_valid_cyc = 0;
  int     words_seen = 0;
  int     run_base = 0;
  int     act_g = 1;
  bit     hold_en = 1'b0;
  word_t  exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int chans(input logic [2:0] cfg);
    return (cfg == 3'd0) ? 8 : (cfg == 3'd1) ? 16 : (cfg == 3'd2) ? 24 : 32;
  endfunction

  // Reference stream: kernel words then row-major column-pair windows, per (k, c).
  task automatic push_run(input int fd, input logic [2:0] c_i, input logic [2:0] c_o, input int limit);
    int nci, nco, pairs, od, cnt;
    word_t w;
    logic [15:0] a;
    nci = chans(c_i); nco = chans(c_o); pairs = fd / 2; od = fd - 3; cnt = 0;
    for (int k = 0; k < nco; k++) begin
      for (int c = 0; c < nci; c++) begin
        for (int ww = 0; ww < 2; ww++) begin
          if (cnt >= limit) return;
          w.knl = 1'b1;
          w.d = knl_mem(11'((k * nci + c) * 2 + ww));
          exp_q.push_back(w); cnt++;
        end
        for (int r = 0; r < od; r++) begin
          for (int p = 0; p < pairs; p++) begin
            if (cnt >= limit) return;
            w.knl = 1'b0;
            for (int i = 0; i < 4; i++) begin
              a = 16'(c * fd * pairs + (r + i) * pairs + p);
              w.d[8*i +: 8] = a[7:0];
              w.d[8*(i+4) +: 8] = a[15:8];
            end
            exp_q.push_back(w); cnt++;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    word_t got, e;
    for (int g = 0; g < 2; g++) begin
      if (hold[g]) check("valid_low_in_hold", 64'(valid[g]), 64'd0);
      if (valid[g]) begin
        got.knl = knl[g];
        for (int n = 0; n < 8; n++) got.d[8*n +: 8] = dat[g][n];
        check("word_expected", 64'((g == act_g) && (exp_q.size() > 0)), 64'd1);
        if ((g == act_g) && (exp_q.size() > 0)) begin
          e = exp_q.pop_front();
          check("word_knl_flag", 64'(got.knl), 64'(e.knl));
          check("word_data", got.d, e.d);
        end
        words_seen++;
        last_valid_cyc = cyc;
      end
    end
  end

  initial begin : hold_gen
    int left;
    left = 0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    forever begin
      @(posedge clk); #1;
      hold[0] = 1'b0; hold[1] = 1'b0;
      if (hold_en) begin
        if (left == 0 && $urandom_range(0, 7) == 0) left = $urandom_range(1, 5);
        if (left > 0) begin hold[act_g] = 1'b1; left--; end
      end else begin
        left = 0;
      end
    end
  end

  task automatic chk_zero(input int g);
    logic any;
    any = valid[g] | knl[g] | busy[g] | done[g] | knl_re[g] | fm_re[g] | (|knl_addr[g]);
    for (int i = 0; i < 4; i++) any |= |fm_addr[g][i];
    for (int n = 0; n < 8; n++) any |= |dat[g][n];
    check("reset_outputs_zero", 64'(any), 64'd0);
    check("reset_busy_low", 64'(busy[g]), 64'd0);
  endtask

  task automatic pulse_start(input int g, input logic [2:0] c_i, input logic [2:0] c_o);
    @(posedge clk); #1;
    ci[g] = c_i; co[g] = c_o; start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
  endtask

  task automatic check_latency(input int g);
    int lat;
    lat = 0;
    @(negedge clk);
    check("busy_after_start", 64'(busy[g]), 64'd1);
    while (!valid[g] && lat < 20) begin
      @(negedge clk); lat++;
      if (lat == 1) begin
        check("first_knl_re", 64'(knl_re[g]), 64'd1);
        check("first_knl_addr", 64'(knl_addr[g]), 64'd0);
      end
    end
    check("first_valid_latency", 64'(lat), 64'd3);
  endtask

  task automatic wait_words(input int g, input int n);
    int cy;
    cy = 0;
    while ((words_seen - run_base) < n && cy < n * 4 + 200) begin
      @(negedge clk); cy++;
      check("busy_while_running", 64'(busy[g]), 64'd1);
    end
    check("words_reached", 64'((words_seen - run_base) >= n), 64'd1);
  endtask

  task automatic wait_done(input int g, input int total);
    int cy;
    cy = 0;
    while (!done[g] && cy < total * 4 + 200) begin
      @(negedge clk); cy++;
      if (!done[g]) check("busy_until_done", 64'(busy[g]), 64'd1);
    end
    check("done_seen", 64'(done[g]), 64'd1);
    check("busy_low_at_done", 64'(busy[g]), 64'd0);
    check("word_count", 64'(words_seen - run_base), 64'(total));
    check("done_one_after_last_word", 64'(cyc - last_valid_cyc), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("done_single_pulse", 64'(done[g]), 64'd0);
    check("idle_after_done", 64'(busy[g]), 64'd0);
  endtask

  task automatic async_reset(input int g);
    hold_en = 1'b0;
    @(negedge clk);
    rst[g] = 1'b1;
    #1;
    chk_zero(g);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst[g] = 1'b0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; ci[g] = 3'd0; co[g] = 3'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0); chk_zero(1);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk_zero(0); chk_zero(1);

    // Start coinciding with reset must be dropped.
    @(posedge clk); #1; rst[1] = 1'b1; start[1] = 1'b1;
    @(posedge clk); #1; rst[1] = 1'b0; start[1] = 1'b0;
    @(negedge clk);
    check("start_during_reset_ignored", 64'(busy[1]), 64'd0);

    // Small fmap, full run, no hold: latency, count and done timing.
    act_g = 1;
    push_run(8, 3'd0, 3'd0, 1 << 30);
    run_base = words_seen;
    pulse_start(1, 3'd0, 3'd0);
    check_latency(1);
    wait_done(1, 8 * 8 * 22);

    // Small fmap, holds and ignored restarts with a different config.
    push_run(8, 3'd1, 3'd0, 1 << 30);
    run_base = words_seen;
    pulse_start(1, 3'd1, 3'd0);
    hold_en = 1'b1;
    wait_words(1, 10);
    pulse_start(1, 3'd3, 3'd3);
    wait_words(1, 300);
    pulse_start(1, 3'd2, 3'd2);
    wait_done(1, 16 * 8 * 22);
    hold_en = 1'b0;

    // Full-size fmap: holds plus restarts at words 10 and 3000, crossing into channel 1.
    act_g = 0;
    push_run(64, 3'd0, 3'd0, 3200);
    run_base = words_seen;
    pulse_start(0, 3'd0, 3'd0);
    check_latency(0);
    hold_en = 1'b1;
    wait_words(0, 10);
    pulse_start(0, 3'd3, 3'd3);
    wait_words(0, 3000);
    pulse_start(0, 3'd3, 3'd3);
    wait_words(0, 3100);
    async_reset(0);

    // Reset near word 500, then the replay starts again from kernel address 0.
    push_run(64, 3'd0, 3'd0, 600);
    run_base = words_seen;
    pulse_start(0, 3'd0, 3'd0);
    check_latency(0);
    wait_words(0, 500);
    async_reset(0);
    push_run(64, 3'd0, 3'd0, 100);
    run_base = words_seen;
    pulse_start(0, 3'd0, 3'd0);
    check_latency(0);
    wait_words(0, 60);
    async_reset(0);

    // 16x16 config up to word 1954*16 (k=1, c=0).
    push_run(64, 3'd1, 3'd1, 31400);
    run_base = words_seen;
    pulse_start(0, 3'd1, 3'd1);
    wait_words(0, 1954 * 16 + 36);
    async_reset(0);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
